instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Sequential instruction-fetch front end that produces the instruction word whose opcode field feeds main_decoder. It holds the PC, fetches each word over a request/acknowledge instruction-memory interface, and presents the word until the core commits it. On commit it computes the next PC from the jump and branch results returned by the control path.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be a multiple of 4
TIMEOUT, 16, max cycles FETCH waits for imem_ack before flagging an error (must be ≥1)
CNT_WIDTH, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  byte address of fetch; equals pc
imem_rdata  input  32  instruction word; sampled when imem_req & imem_ack
imem_ack  input  1  memory acknowledge; valid only while imem_req=1
instr  output  32  registered instruction word
opcode  output  6  instr[31:26], to main_decoder
instr_valid  output  1  instr holds a fetched, uncommitted word
commit  input  1  core retires current instruction this cycle
stall  input  1  blocks commit
jump  input  1  from main_decoder
branch  input  1  from main_decoder
zero  input  1  ALU zero flag
imm_ext  input  32  sign-extended immediate
jump_target  input  26  instr[25:0] field
pc  output  32  current PC
pc_plus4  output  32  pc + 4, modulo 2^32
fetch_err  output  1  sticky fetch-timeout flag
retired_cnt  output  CNT_WIDTH  committed-instruction count, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, retired_cnt=0, timeout counter=0. Outputs change immediately on reset assertion, including mid-fetch; imem_req drops without waiting for ack.
- States: IDLE, FETCH, HOLD, HALT.
- IDLE: next edge goes to FETCH with imem_req=1. This is the first edge after rst_n deasserts.
- FETCH:
  - imem_req=1 and imem_addr=pc are held stable until ack.
  - At an edge with imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to HOLD. Minimum fetch latency is 1 cycle from imem_req rising.
  - The timeout counter increments on each edge without ack. After it reaches TIMEOUT: fetch_err<=1, imem_req<=0, go to HALT.
- HOLD:
  - instr_valid=1; instr and pc stay stable.
  - At an edge with commit=1 and stall=0:
    - pc<=next_pc.
    - instr_valid<=0.
    - retired_cnt increments, saturating at all-ones.
    - Go to FETCH with imem_req=1; the timeout counter clears.
  - commit with stall=1 is ignored; the state stays HOLD.
- HALT: terminal state. It is left only by reset. instr_valid=0, imem_req=0.
- next_pc priority:
  - jump=1: {pc_plus4[31:28], jump_target, 2'b00}.
  - else branch=1 and zero=1: pc_plus4 + (imm_ext << 2), 32-bit wrap.
  - else: pc_plus4.
  - jump wins when jump and branch are both asserted.
- Inputs are ignored outside their state:
  - imem_ack is ignored outside FETCH.
  - commit, jump and branch are ignored outside HOLD.
- PC wrap: pc=32'hFFFF_FFFC gives pc_plus4=0. Sequential next_pc wraps to 0.
- pc_plus4 is combinational from pc.

Test Plan:
- Reset then ack on 2nd FETCH cycle with rdata=32'h2008_0005 -> imem_addr=0, opcode=6'h08, instr_valid=1; commit -> pc=4, retired_cnt=1.
- In HOLD at pc=0x40, branch=1, zero=1, imm_ext=32'hFFFF_FFFE, commit -> pc=0x3C. Repeat with zero=0 -> pc=0x44.
- pc=0x1000_0010, jump=1, branch=1, zero=1, jump_target=26'h0000100, commit -> pc=0x1000_0400 (jump priority).
- commit=1 with stall=1 for 3 cycles -> pc, instr and retired_cnt are unchanged; stall=0 -> one advance only.
- Never ack with TIMEOUT=16 -> fetch_err=1 after 16 waiting edges, state HALT, imem_req=0. Later acks and commits are ignored until rst_n pulses low.
- Assert rst_n=0 mid-FETCH -> imem_req, instr_valid and pc clear asynchronously. Also start at pc=32'hFFFF_FFFC with commit and no jump/branch -> pc=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Sequential instruction-fetch front end. Holds the PC and fetches one word
//   per instruction over a req/ack memory interface. The word is presented on
//   instr/opcode until the core commits it. On commit, the next PC is chosen
//   from the jump/branch results of the control path. A fetch that waits too
//   long for an ack parks the unit in HALT with a sticky error flag.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   imem_req/addr           fetch request and byte address (addr == pc)
//   imem_rdata/ack          returned word, sampled on req & ack
//   instr, opcode           held instruction word and its [31:26] field
//   instr_valid             instr holds a fetched, uncommitted word
//   commit, stall           retire request; stall blocks it
//   jump, branch, zero      control-path results used for next-PC selection
//   imm_ext, jump_target    branch offset (in words) and jump field
//   pc, pc_plus4            current PC and its sequential successor
//   fetch_err               sticky fetch-timeout flag
//   retired_cnt             saturating committed-instruction count
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          TIMEOUT   = 16,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_rdata,
  input  logic                 imem_ack,
  output logic [31:0]          instr,
  output logic [5:0]           opcode,
  output logic                 instr_valid,
  input  logic                 commit,
  input  logic                 stall,
  input  logic                 jump,
  input  logic                 branch,
  input  logic                 zero,
  input  logic [31:0]          imm_ext,
  input  logic [25:0]          jump_target,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 fetch_err,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] ret_q, ret_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [31:0]          next_pc;
  logic                 do_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      err_q   <= 1'b0;
      ret_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-PC selection: jump beats a taken branch, which beats sequential.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    next_pc  = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + (imm_ext << 2);
    end
  end

  assign do_commit = commit && !stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    ret_d   = ret_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        tmo_d   = '0;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end else if (tmo_q == TMO_LAST) begin
          // This edge is the TIMEOUT-th one spent waiting.
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      HOLD: begin
        if (do_commit) begin
          pc_d    = next_pc;
          tmo_d   = '0;
          state_d = FETCH;
          if (ret_q != {CNT_WIDTH{1'b1}}) begin
            ret_d = ret_q + 1'b1;
          end
        end
      end
      default: begin
        // HALT: only reset leaves it.
        state_d = HALT;
      end
    endcase
  end

  // Request and valid are pure state decodes, so they follow an async reset
  // immediately and never depend on ack combinationally.
  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == HOLD);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign fetch_err   = err_q;
  assign retired_cnt = ret_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        commit, stall, jump, branch, zero;
  logic [31:0] imm_ext;
  logic [25:0] jump_target;
  logic [31:0] pc, pc_plus4;
  logic        fetch_err;
  logic [15:0] retired_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16),
    .CNT_WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .opcode     (opcode),
    .instr_valid(instr_valid),
    .commit     (commit),
    .stall      (stall),
    .jump       (jump),
    .branch     (branch),
    .zero       (zero),
    .imm_ext    (imm_ext),
    .jump_target(jump_target),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fetch_err  (fetch_err),
    .retired_cnt(retired_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, check its address, ack after 'delay' idle cycles.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr,
                          input logic [31:0] word, input int delay);
    int waited = 0;
    while (!imem_req && waited < 4) begin
      step();
      waited++;
    end
    check_val({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check_val({tag, "_addr"}, imem_addr, exp_addr);
    for (int i = 0; i < delay; i++) step();
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check_val({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check_val({tag, "_instr"}, instr, word);
  endtask

  // One commit cycle with the given control-path results, then check the new PC.
  task automatic do_commit(input string tag, input logic j, input logic b, input logic z,
                           input logic [31:0] imm, input logic [25:0] tgt,
                           input logic [31:0] exp_pc);
    commit = 1'b1; jump = j; branch = b; zero = z; imm_ext = imm; jump_target = tgt;
    step();
    commit = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
    check_val({tag, "_pc"}, pc, exp_pc);
    check_val({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    commit = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
    imm_ext = 32'd0; jump_target = 26'd0;
    #12;
    check_val("rst_pc", pc, 32'd0);
    check_val("rst_req", {31'd0, imem_req}, 32'd0);
    check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("rst_instr", instr, 32'd0);
    check_val("rst_err", {31'd0, fetch_err}, 32'd0);
    check_val("rst_cnt", {16'd0, retired_cnt}, 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("idle_req", {31'd0, imem_req}, 32'd0);

    // First fetch: ack on the 2nd FETCH cycle.
    do_fetch("f0", 32'h0, 32'h2008_0005, 1);
    check_val("f0_opcode", {26'd0, opcode}, 32'h08);
    do_commit("c0", 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 32'h4);
    check_val("c0_cnt", {16'd0, retired_cnt}, 32'd1);
    check_val("c0_pc_plus4", pc_plus4, 32'h8);

    // Jump to 0x40, then taken branch back by 2 words: 0x44 - 8 = 0x3C.
    do_fetch("f1", 32'h4, 32'h0800_0010, 0);
    do_commit("c1", 1'b1, 1'b0, 1'b0, 32'd0, 26'h10, 32'h40);
    do_fetch("f2", 32'h40, 32'h1000_FFFE, 0);
    do_commit("c2", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 26'd0, 32'h3C);
    // Back to 0x40, same branch not taken (zero=0) -> 0x44.
    do_fetch("f3", 32'h3C, 32'h0800_0010, 0);
    do_commit("c3", 1'b1, 1'b0, 1'b0, 32'd0, 26'h10, 32'h40);
    do_fetch("f4", 32'h40, 32'h1000_FFFE, 0);
    do_commit("c4", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'd0, 32'h44);
    // Long branch: 0x48 + 0x03FF_FFF2*4 = 0x1000_0010.
    do_fetch("f5", 32'h44, 32'h1000_0000, 2);
    do_commit("c5", 1'b0, 1'b1, 1'b1, 32'h03FF_FFF2, 26'd0, 32'h1000_0010);
    // Jump wins over taken branch: {0x1, 0x100, 00} = 0x1000_0400.
    do_fetch("f6", 32'h1000_0010, 32'hFC00_0001, 0);
    do_commit("c6", 1'b1, 1'b1, 1'b1, 32'h0000_0020, 26'h0000100, 32'h1000_0400);
    check_val("c6_cnt", {16'd0, retired_cnt}, 32'd7);

    // Stall blocks commit for 3 cycles, then exactly one advance.
    do_fetch("f7", 32'h1000_0400, 32'h8C00_0000, 0);
    commit = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_val("stall_pc", pc, 32'h1000_0400);
    check_val("stall_instr", instr, 32'h8C00_0000);
    check_val("stall_cnt", {16'd0, retired_cnt}, 32'd7);
    check_val("stall_valid", {31'd0, instr_valid}, 32'd1);
    stall = 1'b0;
    step();
    commit = 1'b0;
    check_val("unstall_pc", pc, 32'h1000_0404);
    check_val("unstall_cnt", {16'd0, retired_cnt}, 32'd8);
    step();
    check_val("unstall_once_pc", pc, 32'h1000_0404);

    // Never ack: 16 waiting edges from the commit edge end in HALT.
    for (int i = 0; i < 14; i++) step();
    check_val("tmo_pre_err", {31'd0, fetch_err}, 32'd0);
    check_val("tmo_pre_req", {31'd0, imem_req}, 32'd1);
    step();
    check_val("tmo_err", {31'd0, fetch_err}, 32'd1);
    check_val("tmo_req", {31'd0, imem_req}, 32'd0);
    check_val("tmo_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678; commit = 1'b1;
    for (int i = 0; i < 3; i++) step();
    imem_ack = 1'b0; commit = 1'b0;
    check_val("halt_req", {31'd0, imem_req}, 32'd0);
    check_val("halt_instr", instr, 32'h8C00_0000);
    check_val("halt_pc", pc, 32'h1000_0404);
    check_val("halt_cnt", {16'd0, retired_cnt}, 32'd8);
    check_val("halt_err", {31'd0, fetch_err}, 32'd1);

    // Leave HALT by reset; move to pc=4 and reset asynchronously mid-FETCH.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    check_val("rst2_err", {31'd0, fetch_err}, 32'd0);
    do_fetch("f8", 32'h0, 32'h0000_0000, 0);
    do_commit("c8", 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 32'h4);
    check_val("c8_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_req", {31'd0, imem_req}, 32'd0);
    check_val("async_pc", pc, 32'd0);
    check_val("async_valid", {31'd0, instr_valid}, 32'd0);
    check_val("async_cnt", {16'd0, retired_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Branch from 0 to 0xFFFF_FFFC (4 + -8), then sequential wrap to 0.
    do_fetch("f9", 32'h0, 32'h1000_FFFE, 0);
    do_commit("c9", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 26'd0, 32'hFFFF_FFFC);
    check_val("wrap_pc_plus4", pc_plus4, 32'd0);
    do_fetch("f10", 32'hFFFF_FFFC, 32'h0000_0000, 0);
    do_commit("c10", 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 32'h0);
    check_val("c10_cnt", {16'd0, retired_cnt}, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
